// File: rtl/edge_frame_sequencer_if.sv
// Memory-master port of the edge frame sequencer: one request channel, one read-return channel.
interface edge_frame_sequencer_if #(
    parameter int unsigned PIX_W = 8
) ();
    logic             mem_req;
    logic             mem_wr;
    logic [31:0]      mem_addr;
    logic [PIX_W-1:0] mem_wdata;
    logic             mem_grant;
    logic             mem_rvalid;
    logic [PIX_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_grant, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_grant, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/edge_frame_sequencer.sv
// Walks every interior pixel of a frame: fetches its 3x3 window, fires the core, writes the result.
// Optional EDGE_SEQ_BORDER_EN: zero-writes all border pixels after the interior pass.
module edge_frame_sequencer #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned DIM_W = 16
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic [DIM_W-1:0]       img_width,
    input  logic [DIM_W-1:0]       img_height,
    input  logic [31:0]            start_raddr,
    input  logic [31:0]            start_waddr,
    edge_frame_sequencer_if.master mem,
    output logic                   pix_shift,
    output logic                   pix_valid,
    output logic [1:0]             pix_row,
    output logic [PIX_W-1:0]       pix_data,
    output logic                   core_start,
    input  logic                   core_done,
    input  logic [PIX_W-1:0]       core_result,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [3:0] {
        IDLE, CHECK, SHIFT, FETCH_REQ, FETCH_WAIT, CORE_GO, CORE_WAIT, WR_REQ, NEXT, FIN
`ifdef EDGE_SEQ_BORDER_EN
        , BORDER
`endif
    } state_t;

    state_t           state;
    logic [DIM_W-1:0] cfg_w, cfg_h;
    logic [31:0]      cfg_raddr, cfg_waddr;
    logic [DIM_W-1:0] x, y, col;
    logic [1:0]       r;
    logic [3:0]       fetch_cnt;
    logic [31:0]      row_off;

    logic [31:0] w32_c, row_adj_c, rd_addr_c, wr_addr_c;
    logic [1:0]  rd_row_c;
    logic        small_c, fetch_last_c, x_more_c, y_more_c;

    // Read address of the next request; in FETCH_WAIT it targets the following row of the column
    always_comb begin
        w32_c    = 32'(cfg_w);
        rd_row_c = (state == FETCH_WAIT) ? r + 2'd1 : r;
        case (rd_row_c)
            2'd0:    row_adj_c = 32'd0 - w32_c;
            2'd1:    row_adj_c = 32'd0;
            default: row_adj_c = w32_c;
        endcase
        rd_addr_c    = cfg_raddr + row_off + 32'(col) + row_adj_c;
        wr_addr_c    = cfg_waddr + row_off + 32'(x);
        small_c      = (cfg_w < DIM_W'(3)) || (cfg_h < DIM_W'(3));
        fetch_last_c = (fetch_cnt == ((x == DIM_W'(1)) ? 4'd8 : 4'd2));
        x_more_c     = (x < cfg_w - DIM_W'(2));
        y_more_c     = (y < cfg_h - DIM_W'(2));
    end

`ifdef EDGE_SEQ_BORDER_EN
    logic is_border_c, border_adv_c, bx_last_c, by_last_c;

    always_comb begin
        bx_last_c    = (x == cfg_w - DIM_W'(1));
        by_last_c    = (y == cfg_h - DIM_W'(1));
        is_border_c  = (x == '0) || bx_last_c || (y == '0) || by_last_c;
        border_adv_c = mem.mem_req ? mem.mem_grant : !is_border_c;
    end
`endif

    // Frame FSM; all outputs registered
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            cfg_w         <= '0;
            cfg_h         <= '0;
            cfg_raddr     <= '0;
            cfg_waddr     <= '0;
            x             <= '0;
            y             <= '0;
            col           <= '0;
            r             <= '0;
            fetch_cnt     <= '0;
            row_off       <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_wr    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            pix_shift     <= 1'b0;
            pix_valid     <= 1'b0;
            pix_row       <= '0;
            pix_data      <= '0;
            core_start    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            pix_shift  <= 1'b0;
            pix_valid  <= 1'b0;
            core_start <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cfg_w     <= img_width;
                    cfg_h     <= img_height;
                    cfg_raddr <= start_raddr;
                    cfg_waddr <= start_waddr;
                    done      <= 1'b0;
                    busy      <= 1'b1;
                    state     <= CHECK;
                end
                CHECK: if (small_c) begin
`ifdef EDGE_SEQ_BORDER_EN
                    if ((cfg_w == '0) || (cfg_h == '0)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        x       <= '0;
                        y       <= '0;
                        row_off <= '0;
                        state   <= BORDER;
                    end
`else
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= FIN;
`endif
                end else begin
                    x         <= DIM_W'(1);
                    y         <= DIM_W'(1);
                    col       <= '0;
                    r         <= '0;
                    fetch_cnt <= '0;
                    row_off   <= w32_c;
                    pix_shift <= 1'b1;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    mem.mem_req  <= 1'b1;
                    mem.mem_wr   <= 1'b0;
                    mem.mem_addr <= rd_addr_c;
                    state        <= FETCH_REQ;
                end
                FETCH_REQ: if (mem.mem_grant) begin
                    mem.mem_req <= 1'b0;
                    state       <= FETCH_WAIT;
                end
                FETCH_WAIT: if (mem.mem_rvalid) begin
                    pix_valid <= 1'b1;
                    pix_data  <= mem.mem_rdata;
                    pix_row   <= r;
                    fetch_cnt <= fetch_cnt + 4'd1;
                    if (fetch_last_c) begin
                        core_start <= 1'b1;
                        state      <= CORE_GO;
                    end else if (r == 2'd2) begin
                        r         <= '0;
                        col       <= col + DIM_W'(1);
                        pix_shift <= 1'b1;
                        state     <= SHIFT;
                    end else begin
                        r            <= r + 2'd1;
                        mem.mem_req  <= 1'b1;
                        mem.mem_wr   <= 1'b0;
                        mem.mem_addr <= rd_addr_c;
                        state        <= FETCH_REQ;
                    end
                end
                CORE_GO: state <= CORE_WAIT;
                CORE_WAIT: if (core_done) begin
                    mem.mem_req   <= 1'b1;
                    mem.mem_wr    <= 1'b1;
                    mem.mem_addr  <= wr_addr_c;
                    mem.mem_wdata <= core_result;
                    state         <= WR_REQ;
                end
                WR_REQ: if (mem.mem_grant) begin
                    mem.mem_req <= 1'b0;
                    mem.mem_wr  <= 1'b0;
                    state       <= NEXT;
                end
                NEXT: begin
                    fetch_cnt <= '0;
                    r         <= '0;
                    if (x_more_c) begin
                        x         <= x + DIM_W'(1);
                        col       <= x + DIM_W'(2);
                        pix_shift <= 1'b1;
                        state     <= SHIFT;
                    end else if (y_more_c) begin
                        y         <= y + DIM_W'(1);
                        x         <= DIM_W'(1);
                        col       <= '0;
                        row_off   <= row_off + w32_c;
                        pix_shift <= 1'b1;
                        state     <= SHIFT;
                    end else begin
`ifdef EDGE_SEQ_BORDER_EN
                        x       <= '0;
                        y       <= '0;
                        row_off <= '0;
                        state   <= BORDER;
`else
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
`endif
                    end
                end
`ifdef EDGE_SEQ_BORDER_EN
                // Raster scan of the whole frame, one zero write per border pixel
                BORDER: begin
                    if (!mem.mem_req && is_border_c) begin
                        mem.mem_req   <= 1'b1;
                        mem.mem_wr    <= 1'b1;
                        mem.mem_addr  <= wr_addr_c;
                        mem.mem_wdata <= '0;
                    end
                    if (mem.mem_req && mem.mem_grant) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_wr  <= 1'b0;
                    end
                    if (border_adv_c) begin
                        if (!bx_last_c) begin
                            x <= x + DIM_W'(1);
                        end else if (!by_last_c) begin
                            x       <= '0;
                            y       <= y + DIM_W'(1);
                            row_off <= row_off + w32_c;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
`endif
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
